// File: rtl/ex_stage.sv
// MIPS32 execute stage: logic/shift ALU plus iterative radix-2 divider.
// Divider, FSM and HI/LO outputs are compiled only when MDU_DIV_EN is defined.
package ex_pkg;
    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_SLLV_OP = 8'b00000100;
    localparam logic [7:0] EXE_SRLV_OP = 8'b00000110;
    localparam logic [7:0] EXE_SRAV_OP = 8'b00000111;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
endpackage

module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              annul_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stallreq_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] shift_res;
    logic [DATA_W-1:0] result;
    logic              is_div;

    assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    // Immediate forms carry rt in operand 1; variable forms carry rt in operand 2.
    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP:  shift_res = reg1_i << reg2_i[4:0];
            EXE_SRL_OP:  shift_res = reg1_i >> reg2_i[4:0];
            EXE_SRA_OP:  shift_res = $unsigned($signed(reg1_i) >>> reg2_i[4:0]);
            EXE_SLLV_OP: shift_res = reg2_i << reg1_i[4:0];
            EXE_SRLV_OP: shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRAV_OP: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default:     shift_res = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (alusel_i)
            EXE_RES_LOGIC: result = logic_res;
            EXE_RES_SHIFT: result = shift_res;
            default:       result = '0;
        endcase
    end

    assign wd_o    = rst ? wd_i : 5'd0;
    assign wreg_o  = rst & wreg_i & ~is_div;
    assign wdata_o = rst ? result : '0;

`ifdef MDU_DIV_EN
    localparam int CW = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvs;
    logic              neg_q;
    logic              neg_r;

    logic              sgn;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;
    logic              ge;
    logic [DATA_W-1:0] q_new;
    logic [DATA_W-1:0] r_new;
    logic              start;
    logic              done;

    assign sgn   = (aluop_i == EXE_DIV_OP);
    assign a_mag = (sgn && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
    assign b_mag = (sgn && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
    assign start = is_div && !annul_i;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial = {rem, quo[DATA_W-1]};
    assign diff  = trial - {1'b0, dvs};
    assign ge    = trial >= {1'b0, dvs};
    assign q_new = {quo[DATA_W-2:0], ge};
    assign r_new = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neg_q <= sgn & (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                        neg_r <= sgn & reg1_i[DATA_W-1];
                        dvs   <= b_mag;
                        cnt   <= '0;
                        if (reg2_i == '0) begin
                            rem   <= reg1_i;
                            quo   <= '1;
                            state <= S_DONE;
                        end else begin
                            rem   <= '0;
                            quo   <= a_mag;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(DATA_W - 1)) begin
                            quo   <= neg_q ? -q_new : q_new;
                            rem   <= neg_r ? -r_new : r_new;
                            state <= S_DONE;
                        end else begin
                            quo <= q_new;
                            rem <= r_new;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign done       = rst && (state == S_DONE);
    assign whilo_o    = done;
    assign hi_o       = done ? rem : '0;
    assign lo_o       = done ? quo : '0;
    assign stallreq_o = rst && !annul_i &&
                        (((state == S_IDLE) && is_div) || (state == S_BUSY));
`else
    logic unused_div;

    assign unused_div = ^{clk, annul_i};
    assign whilo_o    = 1'b0;
    assign hi_o       = '0;
    assign lo_o       = '0;
    assign stallreq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: logic/shift results, reset gating,
// and (when MDU_DIV_EN is defined) divider latency, results, annul and reset.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total;
    int bad;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .annul_i    (annul_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wr;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_wd"},    32'(wd_o),       32'd0);
        chk({tag, "_wreg"},  32'(wreg_o),     32'd0);
        chk({tag, "_wdata"}, wdata_o,         32'd0);
        chk({tag, "_stall"}, 32'(stallreq_o), 32'd0);
        chk({tag, "_whilo"}, 32'(whilo_o),    32'd0);
        chk({tag, "_hi"},    hi_o,            32'd0);
        chk({tag, "_lo"},    lo_o,            32'd0);
    endtask

    task automatic alu(input string tag, input logic [7:0] op,
                       input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        drive(op, sel, a, b, 5'd7, 1'b1);
        #1;
        chk(tag, wdata_o, exp);
    endtask

`ifdef MDU_DIV_EN
    // Issues a divide at a negedge and counts stall cycles up to the whilo pulse.
    task automatic div_run(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_stalls, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int stalls;
        bit seen;
        stalls = 0;
        seen   = 1'b0;
        @(negedge clk);
        drive(op, EXE_RES_NOP, a, b, 5'd9, 1'b1);
        #1;
        chk({tag, "_wreg"}, 32'(wreg_o), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (whilo_o) begin
                seen = 1'b1;
                break;
            end
            if (stallreq_o) stalls++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_whilo"},  32'(seen),       32'd1);
        chk({tag, "_stalls"}, 32'(stalls),     32'(exp_stalls));
        chk({tag, "_lo"},     lo_o,            exp_lo);
        chk({tag, "_hi"},     hi_o,            exp_hi);
        chk({tag, "_dstall"}, 32'(stallreq_o), 32'd0);
    endtask

    task automatic no_whilo(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (whilo_o) pulses++;
        end
        chk(tag, 32'(pulses), 32'd0);
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        annul_i = 1'b0;
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd3, 1'b1);
        #1;
        all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;

        chk("or_wdata", wdata_o, 32'h00FFF0FF);
        chk("or_wd",    32'(wd_o),   32'd3);
        chk("or_wreg",  32'(wreg_o), 32'd1);

        alu("and",  EXE_AND_OP,  EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 32'h000000F0);
        alu("xor",  EXE_XOR_OP,  EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 32'h00FFF00F);
        alu("nor",  EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 32'hFF000F00);
        alu("srav", EXE_SRAV_OP, EXE_RES_SHIFT, 32'd4,        32'h80000010, 32'hF8000001);
        alu("srl",  EXE_SRL_OP,  EXE_RES_SHIFT, 32'h80000000, 32'd31,       32'h00000001);
        alu("sll",  EXE_SLL_OP,  EXE_RES_SHIFT, 32'h00000001, 32'd31,       32'h80000000);
        alu("sra0", EXE_SRA_OP,  EXE_RES_SHIFT, 32'h80000000, 32'd0,        32'h80000000);
        alu("sra",  EXE_SRA_OP,  EXE_RES_SHIFT, 32'h80000000, 32'd8,        32'hFF800000);
        alu("sllv", EXE_SLLV_OP, EXE_RES_SHIFT, 32'd36,       32'h0000000F, 32'h000000F0);
        alu("srlv", EXE_SRLV_OP, EXE_RES_SHIFT, 32'd8,        32'h80000000, 32'h00800000);
        alu("nop",  EXE_OR_OP,   EXE_RES_NOP,   32'h12345678, 32'h1,        32'h00000000);
        alu("bad",  EXE_OR_OP,   3'b111,        32'h12345678, 32'h1,        32'h00000000);
        alu("mism", EXE_SLL_OP,  EXE_RES_LOGIC, 32'h12345678, 32'h1,        32'h00000000);

`ifdef MDU_DIV_EN
        div_run("div_m7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33,
                32'hFFFFFFFD, 32'hFFFFFFFF);
        div_run("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 33,
                32'hFFFFFFFD, 32'h00000001);
        div_run("div_wrap", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 33,
                32'h80000000, 32'h00000000);
        div_run("divu_big", EXE_DIVU_OP, 32'hFFFFFFFF, 32'h00000010, 33,
                32'h0FFFFFFF, 32'h0000000F);
        div_run("divu_z", EXE_DIVU_OP, 32'h12345678, 32'd0, 1,
                32'hFFFFFFFF, 32'h12345678);
        div_run("div_z", EXE_DIV_OP, 32'h87654321, 32'd0, 1,
                32'hFFFFFFFF, 32'h87654321);

        @(negedge clk);
        drive(EXE_OR_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("pulse_once", 32'(whilo_o), 32'd0);

        // Annul in BUSY cycle 10 of a DIVU 100/7.
        @(negedge clk);
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd1, 1'b0);
        for (int i = 0; i < 10; i++) @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul_stall", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        annul_i = 1'b0;
        drive(EXE_OR_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("annul_idle", 32'(stallreq_o), 32'd0);
        no_whilo("annul_no_whilo", 40);
        div_run("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33,
                32'd14, 32'd2);

        // Reset in BUSY cycle 20.
        @(negedge clk);
        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd4, 1'b1);
        for (int i = 0; i < 20; i++) @(negedge clk);
        #1;
        chk("busy_stall", 32'(stallreq_o), 32'd1);
        rst = 1'b0;
        #1;
        all_zero("midrst");
        @(negedge clk);
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF00FF, 5'd3, 1'b1);
        rst = 1'b1;
        #1;
        chk("post_or", wdata_o, 32'h00FFF0FF);
        chk("post_stall", 32'(stallreq_o), 32'd0);
        no_whilo("post_no_whilo", 40);
`else
        @(negedge clk);
        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd2, 1'b1);
        #1;
        chk("nodiv_wreg",  32'(wreg_o),     32'd0);
        chk("nodiv_wdata", wdata_o,         32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("nodiv_stall", 32'(stallreq_o), 32'd0);
            chk("nodiv_whilo", 32'(whilo_o),    32'd0);
            chk("nodiv_lo",    lo_o,            32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
